// File: rtl/operand_forward_unit_pkg.sv
// Shared definitions for the operand forwarding unit: stall FSM encoding,
// select-bit positions and default widths.
package fwd_pkg;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_STALL = 1'b1
   } fwd_state_e;

   // Position of the register-file bit inside a per-port one-hot select.
   localparam int SEL_RF       = 0;
   // Source i occupies select bit SEL_SRC_BASE + i.
   localparam int SEL_SRC_BASE = 1;

   localparam int DEF_DW        = 32;
   localparam int DEF_AW        = 5;
   localparam int DEF_N_READ    = 2;
   localparam int DEF_N_SRC     = 3;
   localparam int DEF_MAX_STALL = 15;
   localparam int DEF_CW        = 4;

endpackage

// File: rtl/operand_forward_unit_port_sel.sv
// One read port of the forwarding unit: finds the youngest in-flight writer
// of the requested register, builds the one-hot select, muxes the data and
// flags a hazard when that writer's data is not yet available.
module fwd_port_sel
   import fwd_pkg::*;
#(
   parameter int DW    = DEF_DW,
   parameter int AW    = DEF_AW,
   parameter int N_SRC = DEF_N_SRC
) (
   input  logic [AW-1:0]       addr_i,
   input  logic [DW-1:0]       rf_data_i,
   input  logic [N_SRC-1:0]    src_valid_i,
   input  logic [N_SRC*AW-1:0] src_dest_i,
   input  logic [N_SRC*DW-1:0] src_data_i,
   input  logic [N_SRC-1:0]    src_ready_i,
   output logic [N_SRC:0]      sel_o,
   output logic [DW-1:0]       data_o,
   output logic                hazard_o
);

   // Priority match: scan oldest to youngest so the youngest match is the
   // last assignment and shadows older ones, ready or not. Register zero is
   // hardwired and never forwarded.
   always_comb begin
      sel_o         = '0;
      sel_o[SEL_RF] = 1'b1;
      data_o        = rf_data_i;
      hazard_o      = 1'b0;
      if (addr_i != '0) begin
         for (int i = N_SRC - 1; i >= 0; i--) begin
            if (src_valid_i[i] && (src_dest_i[i*AW +: AW] == addr_i)) begin
               sel_o                   = '0;
               sel_o[SEL_SRC_BASE + i] = 1'b1;
               data_o                  = src_data_i[i*DW +: DW];
               hazard_o                = ~src_ready_i[i];
            end
         end
      end
   end

endmodule

// File: rtl/operand_forward_unit.sv
// Operand forwarding unit: resolves every ID-stage read port against the
// in-flight write-back sources, stalls on load-use hazards, tracks stall
// length with a sticky watchdog, and registers the resolved operands as the
// operand half of the ID/EX pipeline register.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_RUN   | no stall in progress; counter held at zero
//   ST_STALL | stall raised last cycle; counter measures its length
module operand_forward_unit
   import fwd_pkg::*;
#(
   parameter int DW        = DEF_DW,
   parameter int AW        = DEF_AW,
   parameter int N_READ    = DEF_N_READ,
   parameter int N_SRC     = DEF_N_SRC,
   parameter int MAX_STALL = DEF_MAX_STALL,
   parameter int CW        = DEF_CW
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        id_valid,
   input  logic                        id_hold,
   input  logic [N_READ*AW-1:0]        rs_addr,
   input  logic [N_READ*DW-1:0]        rf_data,
   input  logic [N_SRC-1:0]            src_valid,
   input  logic [N_SRC*AW-1:0]         src_dest,
   input  logic [N_SRC*DW-1:0]         src_data,
   input  logic [N_SRC-1:0]            src_ready,
   output logic                        stall,
   output logic                        ex_valid,
   output logic [N_READ*DW-1:0]        ex_op,
   output logic [N_READ*(N_SRC+1)-1:0] ex_sel,
   output logic [CW-1:0]               stall_cnt,
   output logic                        stall_timeout
);

   localparam int SW = N_SRC + 1;

   localparam logic [CW-1:0] CNT_MAX  = '1;
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   // Counter value whose increment reaches the watchdog threshold.
   localparam logic [CW-1:0] TRIP_PRE = CW'(MAX_STALL - 1);

   // Register-file select on every port; the reset value of ex_sel.
   function automatic logic [N_READ*SW-1:0] rf_sel_all();
      logic [N_READ*SW-1:0] v;
      v = '0;
      for (int k = 0; k < N_READ; k++) begin
         v[k*SW + SEL_RF] = 1'b1;
      end
      return v;
   endfunction

   localparam logic [N_READ*SW-1:0] SEL_RST = rf_sel_all();

   logic [N_READ-1:0]    hazard;
   logic [N_READ*DW-1:0] mux_op;
   logic [N_READ*SW-1:0] mux_sel;

   fwd_state_e           state_q;
   logic [CW-1:0]        cnt_q;
   logic                 timeout_q;
   logic                 ex_valid_q;
   logic [N_READ*DW-1:0] ex_op_q;
   logic [N_READ*SW-1:0] ex_sel_q;

   for (genvar k = 0; k < N_READ; k++) begin : g_port
      fwd_port_sel #(
         .DW    (DW),
         .AW    (AW),
         .N_SRC (N_SRC)
      ) u_port_sel (
         .addr_i      (rs_addr[k*AW +: AW]),
         .rf_data_i   (rf_data[k*DW +: DW]),
         .src_valid_i (src_valid),
         .src_dest_i  (src_dest),
         .src_data_i  (src_data),
         .src_ready_i (src_ready),
         .sel_o       (mux_sel[k*SW +: SW]),
         .data_o      (mux_op[k*DW +: DW]),
         .hazard_o    (hazard[k])
      );
   end

   // An empty ID slot never stalls, whatever its addresses match.
   assign stall = id_valid & (|hazard);

   // Stall FSM with saturating length counter and sticky watchdog; id_hold
   // deliberately has no effect here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_RUN;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         case (state_q)
            ST_RUN: begin
               cnt_q <= '0;
               if (stall) begin
                  state_q <= ST_STALL;
               end
            end
            ST_STALL: begin
               if (!stall) begin
                  state_q <= ST_RUN;
                  cnt_q   <= '0;
               end else if (cnt_q != CNT_MAX) begin
                  cnt_q <= cnt_q + CNT_ONE;
                  if (cnt_q == TRIP_PRE) begin
                     timeout_q <= 1'b1;
                  end
               end
            end
            default: begin
               state_q <= ST_RUN;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   // ID/EX operand register: hold freezes everything, a stall injects a
   // bubble but keeps the last operands, otherwise load the mux result.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid_q <= 1'b0;
         ex_op_q    <= '0;
         ex_sel_q   <= SEL_RST;
      end else if (id_hold) begin
         ex_valid_q <= ex_valid_q;
      end else if (stall) begin
         ex_valid_q <= 1'b0;
      end else begin
         ex_valid_q <= id_valid;
         ex_op_q    <= mux_op;
         ex_sel_q   <= mux_sel;
      end
   end

   assign ex_valid      = ex_valid_q;
   assign ex_op         = ex_op_q;
   assign ex_sel        = ex_sel_q;
   assign stall_cnt     = cnt_q;
   assign stall_timeout = timeout_q;

endmodule

// File: doc/operand_forward_unit.md
Name: operand_forward_unit

Overview:
- Parametrised successor to the single-operand bypass mux in the 5-stage pipeline.
- Resolves N_READ source operands of the ID-stage instruction against N_SRC in-flight write-back sources, ordered youngest first (EXE, MEM, WB).
- Detects not-yet-available producers (load-use), raises a stall, and inserts bubbles; runs a stall FSM with a watchdog counter.
- Registers the resolved operands, acting as the operand half of the ID/EX pipeline register.

Parameters:
- DW, 32, operand data width.
- AW, 5, register address width.
- N_READ, 2, read ports per instruction (rs, rt).
- N_SRC, 3, forwarding sources; index 0 is youngest (EXE), N_SRC-1 is oldest (WB).
- MAX_STALL, 15, stall-cycle count that trips the watchdog.
- CW, 4, stall counter width; must satisfy 2^CW-1 >= MAX_STALL.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- id_valid  in  1  ID stage holds a valid instruction.
- id_hold  in  1  EX stage cannot accept; freeze outputs.
- rs_addr  in  N_READ*AW  source register addresses; port k at [k*AW +: AW].
- rf_data  in  N_READ*DW  register-file read data per port.
- src_valid  in  N_SRC  source i carries a register write.
- src_dest  in  N_SRC*AW  destination register per source.
- src_data  in  N_SRC*DW  write data per source.
- src_ready  in  N_SRC  src_data valid this cycle; 0 for a load still in EXE.
- stall  out  1  combinational; freeze IF/ID.
- ex_valid  out  1  registered; EX instruction valid.
- ex_op  out  N_READ*DW  registered resolved operands.
- ex_sel  out  N_READ*(N_SRC+1)  registered one-hot selects; bit 0 = regfile, bit i+1 = source i.
- stall_cnt  out  CW  current consecutive stall length.
- stall_timeout  out  1  sticky watchdog flag.

Behaviour:
- Select (combinational, per port k):
  - addr==0 -> regfile, sel bit0; never forwarded.
  - Otherwise the lowest index i with src_valid[i] && src_dest[i]==addr wins.
  - No match -> regfile.
  - A younger match always shadows an older one, even if the younger is not ready.
- hazard_k = winning source not ready. stall = id_valid && OR(hazard_k).
- FSM, 2 states: RUN, STALL.
  - RUN -> STALL when stall=1.
  - STALL -> RUN when stall=0.
  - State transitions ignore id_hold.
- stall_cnt:
  - Cleared in RUN and on the STALL->RUN transition.
  - +1 per cycle in STALL, saturating at 2^CW-1.
  - stall_timeout sets on the edge where stall_cnt reaches MAX_STALL; cleared only by rst.
- Output register, per rising edge, in priority order:
  1. rst: ex_valid=0, ex_op=0, ex_sel=one-hot bit0 per port, state=RUN, stall_cnt=0, stall_timeout=0.
  2. id_hold: ex_valid, ex_op, ex_sel keep their values. FSM and counter still update.
  3. stall: ex_valid=0 (bubble); ex_op and ex_sel keep their values.
  4. Else: ex_valid=id_valid, ex_op/ex_sel take the mux result.
- Latency: one cycle from ID inputs to ex_op.
- id_valid=0: stall=0, no hazard, bubble propagates.
- rst asserted mid-stall: next cycle is RUN, cnt=0, stall still combinational from inputs.
- Both ports hitting the same source: each resolves independently with identical data.

Decomposition:
- Shared package fwd_pkg holds:
  - FSM state encoding (RUN=1'b0, STALL=1'b1).
  - Select-bit index constants (SEL_RF=0, SEL_SRC_BASE=1).
  - Default width constants.
- Sub-module fwd_port_sel: one read port's priority match, select, hazard and data mux. Instantiated N_READ times via generate.
- Top level holds the FSM, counter and output register.

Test Plan:
- Dependency on EXE: rs=5; src0 valid, dest=5, data=0x11, ready=1; src2 dest=5, data=0x33 -> next cycle ex_op[0]=0x11, ex_sel[0]=4'b0010.
- Register zero: rs=0, src0 dest=0, data=0xFF, rf_data=0 -> ex_op=0, sel=4'b0001, stall=0.
- Load-use: rs=7; src0 dest=7, ready=0 -> stall=1 and ex_valid=0 for 1 cycle. Next cycle src1 dest=7, ready=1, data=0xAB -> stall=0, ex_op=0xAB, ex_sel=4'b0100.
- Hold priority: id_hold=1 while inputs change -> ex_op, ex_valid, ex_sel unchanged for 3 cycles. Release -> new mux value loaded.
- Watchdog: src0 dest=3, ready=0 held for 16 cycles -> stall_cnt counts 1..15, stall_timeout=1 from cycle 15 and stays set after the stall clears.
- Reset mid-stall: assert rst during the 3rd stall cycle -> ex_valid=0, stall_cnt=0, stall_timeout=0, state RUN on the next edge.
